// File: rtl/cc1200_spi_responder_if.sv
// ----------------------------------------------------------------------------
// cc1200_spi_responder_if
// Purpose : SPI wire bundle between a CC1200 SPI master and the responder.
//           SCLK is carried as a plain port on the responder, not here.
// Signals : CS_n  chip select, active-low (master -> responder)
//           MOSI  serial data master -> responder, MSB first
//           MISO  serial data responder -> master, MSB first
// Modports: master drives CS_n/MOSI and reads MISO; slave is the reverse.
// ----------------------------------------------------------------------------
interface cc1200_spi_responder_if;
  logic CS_n;
  logic MOSI;
  logic MISO;

  modport master (
    output CS_n,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  CS_n,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/cc1200_spi_responder.sv
// ----------------------------------------------------------------------------
// cc1200_spi_responder
// Purpose : SPI target modelling the CC1200 register interface, clocked by the
//           master's SCLK (mode 0, MSB first). Decodes header bytes, serves
//           single/burst register reads and writes, returns the chip status
//           byte during every header and reports command strobes.
// Ports   : SCLK          SPI clock, sole clock of the block
//           rstn          asynchronous reset, active-high
//           spi           SPI bus (CS_n, MOSI in; MISO out), slave modport
//           chip_rdyn     status byte bit 7
//           chip_state    status byte bits 6:4
//           wr_en         one-cycle pulse: register write committed
//           wr_addr       address of the committed write
//           wr_data       data of the committed write
//           strobe_valid  one-cycle pulse: command strobe received
//           strobe_cmd    strobe address (0x30..0x3D)
// ----------------------------------------------------------------------------
module cc1200_spi_responder #(
  parameter int          NREG      = 47,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  SCLK,
  input  logic                  rstn,
  cc1200_spi_responder_if.slave spi,
  input  logic                  chip_rdyn,
  input  logic [2:0]            chip_state,
  output logic                  wr_en,
  output logic [5:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  strobe_valid,
  output logic [5:0]            strobe_cmd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(NREG - 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic       w_cs_n;
  logic       w_mosi;

  state_t     r_state;
  logic [2:0] r_cnt;        // bits received in the current byte
  logic [6:0] r_shift;      // first seven bits of the current byte
  logic       r_read;
  logic       r_burst;
  logic [5:0] r_addr;
  logic [7:0] r_tx;         // byte being shifted out on MISO
  logic       r_armed;      // CS_n has been high since the last transaction
  logic       r_wr_en;
  logic       r_strobe_valid;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [5:0] r_strobe_cmd;
  logic [7:0] r_regs [NREG];
  logic       r_miso;
  logic       r_hdr_first;  // first header bit still pending on MISO

  logic [7:0] w_byte;
  logic       w_last;
  logic [7:0] w_status;
  logic [5:0] w_hdr_addr;
  logic       w_hdr_strobe;
  logic       w_addr_impl;
  logic [5:0] w_next_addr;
  logic [5:0] w_rd_addr;
  logic [7:0] w_rd_data;
  logic       w_wr_commit;
  logic       w_strobe;

  assign w_cs_n = spi.CS_n;
  assign w_mosi = spi.MOSI;

  // --------------------------------------------------------------------------
  // Byte assembly and decode
  // --------------------------------------------------------------------------
  assign w_byte       = {r_shift, w_mosi};
  assign w_last       = (r_cnt == 3'd7);
  assign w_status     = {chip_rdyn, chip_state, 4'b0000};
  assign w_hdr_addr   = w_byte[5:0];
  assign w_hdr_strobe = (w_hdr_addr >= 6'h30) && (w_hdr_addr <= 6'h3D);
  assign w_addr_impl  = (r_addr <= LAST_ADDR);

  // Reserved addresses hold still in a burst so the burst never walks into
  // the strobe range or wraps back onto real registers.
  always_comb begin
    w_next_addr = r_addr;
    if (w_addr_impl) begin
      w_next_addr = (r_addr == LAST_ADDR) ? 6'h00 : r_addr + 6'd1;
    end
  end

  // During a header the read address comes straight from the incoming byte;
  // during a burst it is the address of the following data byte.
  assign w_rd_addr = (r_state == DATA) ? w_next_addr : w_hdr_addr;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_addr <= LAST_ADDR) begin
      w_rd_data = r_regs[w_rd_addr];
    end
  end

  // r_state is cleared asynchronously by CS_n, so a CS_n rise that races the
  // 8th edge leaves these false and the byte is dropped.
  assign w_wr_commit = (r_state == DATA) && w_last && !r_read && w_addr_impl;
  assign w_strobe    = (r_state == HDR) && w_last && w_hdr_strobe;

  // --------------------------------------------------------------------------
  // Transaction FSM (rising edge). CS_n high or reset returns to IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge SCLK or posedge rstn or posedge w_cs_n) begin
    if (rstn | w_cs_n) begin
      r_state        <= IDLE;
      r_cnt          <= 3'd0;
      r_shift        <= 7'd0;
      r_read         <= 1'b0;
      r_burst        <= 1'b0;
      r_addr         <= 6'd0;
      r_tx           <= 8'h00;
      r_wr_en        <= 1'b0;
      r_strobe_valid <= 1'b0;
    end else begin
      r_wr_en        <= w_wr_commit;
      r_strobe_valid <= w_strobe;
      case (r_state)
        IDLE: begin
          // First rising edge of a fresh transaction is header bit 7.
          if (r_armed) begin
            r_state <= HDR;
            r_cnt   <= 3'd1;
            r_shift <= {r_shift[5:0], w_mosi};
            r_tx    <= w_status;
          end
        end
        HDR: begin
          r_cnt   <= r_cnt + 3'd1;
          r_shift <= {r_shift[5:0], w_mosi};
          // Bit 7 already went out; refresh the rest of the status byte.
          if (r_cnt == 3'd0) begin
            r_tx <= w_status;
          end
          if (w_last) begin
            if (w_hdr_strobe) begin
              r_tx <= w_status;
            end else begin
              r_state <= DATA;
              r_read  <= w_byte[7];
              r_burst <= w_byte[6];
              r_addr  <= w_hdr_addr;
              r_tx    <= w_byte[7] ? w_rd_data : 8'h00;
            end
          end
        end
        DATA: begin
          r_cnt   <= r_cnt + 3'd1;
          r_shift <= {r_shift[5:0], w_mosi};
          if (w_last) begin
            if (r_burst) begin
              r_addr <= w_next_addr;
              r_tx   <= r_read ? w_rd_data : 8'h00;
            end else begin
              r_state <= HDR;
              r_tx    <= w_status;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Armed only by CS_n high, so a reset released while CS_n is low waits for
  // a fresh CS_n fall. CS_n high dominates reset.
  always_ff @(posedge SCLK or posedge rstn or posedge w_cs_n) begin
    if (w_cs_n) begin
      r_armed <= 1'b1;
    end else if (rstn) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Register file and held output fields (kept across CS_n high)
  // --------------------------------------------------------------------------
  always_ff @(posedge SCLK or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_wr_addr    <= 6'd0;
      r_wr_data    <= 8'h00;
      r_strobe_cmd <= 6'd0;
    end else begin
      if (w_wr_commit) begin
        r_regs[r_addr] <= w_byte;
        r_wr_addr      <= r_addr;
        r_wr_data      <= w_byte;
      end
      if (w_strobe) begin
        r_strobe_cmd <= w_hdr_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // MISO (falling edge): present the bit the master samples on the next rise
  // --------------------------------------------------------------------------
  always_ff @(negedge SCLK or posedge rstn or posedge w_cs_n) begin
    if (w_cs_n) begin
      r_hdr_first <= 1'b1;
      r_miso      <= 1'b0;
    end else if (rstn) begin
      r_hdr_first <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_hdr_first <= 1'b0;
      r_miso      <= (r_state == IDLE) ? 1'b0 : r_tx[3'd7 - r_cnt];
    end
  end

  // Before the first falling edge the status MSB is driven straight from
  // chip_rdyn so it is valid ahead of the first rising edge.
  assign spi.MISO = r_hdr_first ? (chip_rdyn & ~w_cs_n) : r_miso;

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign strobe_valid = r_strobe_valid;
  assign strobe_cmd   = r_strobe_cmd;

endmodule

// File: tb/tb_cc1200_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_cc1200_spi_responder
// Purpose : self-checking bench for cc1200_spi_responder. Tests queue the
//           expected MISO bytes, write pulses and strobe pulses as they stage
//           stimulus; MISO bytes are compared after each transfer and pulses
//           are compared by a falling-edge monitor.
// ----------------------------------------------------------------------------
module tb_cc1200_spi_responder;

  logic       SCLK;
  logic       rstn;
  logic       chip_rdyn;
  logic [2:0] chip_state;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       strobe_valid;
  logic [5:0] strobe_cmd;

  cc1200_spi_responder_if spi_if ();

  cc1200_spi_responder #(
    .NREG      (47),
    .RESET_VAL (8'h00)
  ) dut (
    .SCLK         (SCLK),
    .rstn         (rstn),
    .spi          (spi_if),
    .chip_rdyn    (chip_rdyn),
    .chip_state   (chip_state),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .strobe_valid (strobe_valid),
    .strobe_cmd   (strobe_cmd)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_q   [$];  // bytes to send in the next transaction
  logic [7:0]  rx_q   [$];  // bytes captured from MISO
  logic [8:0]  miso_q [$];  // {compare, expected byte}
  logic [13:0] wr_q   [$];  // {addr, data}
  logic [5:0]  stb_q  [$];

  // --------------------------------------------------------------------------
  // Stimulus primitives (mode 0: MOSI set while SCLK low, MISO sampled just
  // before the rising edge, 20 ns bit period)
  // --------------------------------------------------------------------------
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_if.MOSI = tx[7-i];
      #5;
      rx[7-i] = spi_if.MISO;
      #5 SCLK = 1'b1;
      #10 SCLK = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_if.CS_n = 1'b0;
    #10;
  endtask

  task automatic cs_hi();
    #10 spi_if.CS_n = 1'b1;
    #20;
  endtask

  task automatic xfer();
    logic [7:0] b;
    logic [7:0] rx;
    cs_lo();
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      spi_bits(b, 8, rx);
      rx_q.push_back(rx);
    end
    cs_hi();
  endtask

  task automatic stage(input logic [7:0] tx, input logic cmp, input logic [7:0] exp);
    tx_q.push_back(tx);
    miso_q.push_back({cmp, exp});
  endtask

  // --------------------------------------------------------------------------
  // Pulse scoreboard: wr_en / strobe_valid sampled on SCLK falling edges
  // --------------------------------------------------------------------------
  always @(negedge SCLK) begin
    logic [13:0] ew;
    logic [5:0]  es;
    if (wr_en === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        ew = wr_q.pop_front();
        if ({wr_addr, wr_data} !== ew) begin
          errors++;
          $display("FAIL wr_pulse: got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, ew[13:8], ew[7:0]);
        end
      end
    end
    if (strobe_valid === 1'b1) begin
      checks++;
      if (stb_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got cmd=%h, required no strobe", strobe_cmd);
      end else begin
        es = stb_q.pop_front();
        if (strobe_cmd !== es) begin
          errors++;
          $display("FAIL strobe_pulse: got cmd=%h, required %h", strobe_cmd, es);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    #20;
    checks++; if (spi_if.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b required 0", spi_if.MISO); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    checks++; if (wr_addr !== 6'h00) begin errors++; $display("FAIL reset_wr_addr: got %h required 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h required 00", wr_data); end
    checks++; if (strobe_valid !== 1'b0) begin errors++; $display("FAIL reset_strobe_valid: got %b required 0", strobe_valid); end
    checks++; if (strobe_cmd !== 6'h00) begin errors++; $display("FAIL reset_strobe_cmd: got %h required 00", strobe_cmd); end
    rstn = 1'b0;
    #20;
    $display("test_reset done");
  endtask

  task automatic test_read_after_reset();
    logic [7:0] rx;
    logic [8:0] e;
    stage(8'h85, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h00);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL read_after_reset_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    $display("test_read_after_reset done");
  endtask

  task automatic test_single_write_read();
    logic [7:0] rx;
    logic [8:0] e;
    wr_q.push_back({6'h05, 8'hA5});
    stage(8'h05, 1'b1, 8'h10);
    stage(8'hA5, 1'b0, 8'h00);
    xfer();
    // Different status so the combinational first bit is exercised as a 1.
    chip_rdyn = 1'b1; chip_state = 3'b101;
    stage(8'h85, 1'b1, 8'hD0);
    stage(8'h00, 1'b1, 8'hA5);
    xfer();
    chip_rdyn = 1'b0; chip_state = 3'b001;
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL single_write_read_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL single_write_missing: got %0d pending writes required 0", wr_q.size()); end
    $display("test_single_write_read done");
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx;
    logic [8:0] e;
    wr_q.push_back({6'h2D, 8'h11});
    wr_q.push_back({6'h2E, 8'h22});
    wr_q.push_back({6'h00, 8'h33});
    stage(8'h6D, 1'b1, 8'h10);
    stage(8'h11, 1'b0, 8'h00);
    stage(8'h22, 1'b0, 8'h00);
    stage(8'h33, 1'b0, 8'h00);
    xfer();
    stage(8'hED, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h11);
    stage(8'h00, 1'b1, 8'h22);
    stage(8'h00, 1'b1, 8'h33);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL burst_wrap_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL burst_write_missing: got %0d pending writes required 0", wr_q.size()); end
    $display("test_burst_wrap done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx;
    logic [8:0] e;
    // Write then read of the same register inside one CS_n window.
    wr_q.push_back({6'h01, 8'h5A});
    stage(8'h01, 1'b1, 8'h10);
    stage(8'h5A, 1'b0, 8'h00);
    stage(8'h81, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h5A);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL back_to_back_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL back_to_back_write_missing: got %0d pending required 0", wr_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reserved();
    logic [7:0] rx;
    logic [8:0] e;
    stage(8'h2F, 1'b1, 8'h10);
    stage(8'h77, 1'b0, 8'h00);
    xfer();
    stage(8'hAF, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h00);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL reserved_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    $display("test_reserved done");
  endtask

  task automatic test_strobes();
    logic [7:0] rx;
    logic [8:0] e;
    stb_q.push_back(6'h36);
    stb_q.push_back(6'h3D);
    stage(8'h36, 1'b1, 8'h10);
    stage(8'h3D, 1'b1, 8'h10);
    xfer();
    stage(8'h85, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'hA5);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL strobes_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    checks++; if (stb_q.size() != 0) begin errors++; $display("FAIL strobe_missing: got %0d pending strobes required 0", stb_q.size()); end
    $display("test_strobes done");
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic [8:0] e;
    cs_lo();
    spi_bits(8'h07, 8, rx);
    checks++; if (rx !== 8'h10) begin errors++; $display("FAIL abort_hdr_status: got %h required 10", rx); end
    spi_bits(8'hFF, 4, rx);
    cs_hi();
    stage(8'h87, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h00);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL abort_followup_miso: got %h required %h", rx, e[7:0]); end
      end
    end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] rx;
    logic [8:0] e;
    wr_q.push_back({6'h10, 8'h55});
    stage(8'h10, 1'b1, 8'h10);
    stage(8'h55, 1'b0, 8'h00);
    xfer();
    cs_lo();
    spi_bits(8'hD0, 8, rx);
    checks++; if (rx !== 8'h10) begin errors++; $display("FAIL midrst_hdr_status: got %h required 10", rx); end
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h55) begin errors++; $display("FAIL midrst_burst_data: got %h required 55", rx); end
    spi_bits(8'h00, 3, rx);
    rstn = 1'b1;
    #5;
    checks++; if (spi_if.MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b required 0", spi_if.MISO); end
    #5 rstn = 1'b0;
    #10;
    // CS_n still low: the block must stay idle until a fresh CS_n fall.
    spi_bits(8'h05, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL midrst_idle_miso0: got %h required 00", rx); end
    spi_bits(8'hEE, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL midrst_idle_miso1: got %h required 00", rx); end
    cs_hi();
    stage(8'h90, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h00);
    xfer();
    stage(8'h85, 1'b1, 8'h10);
    stage(8'h00, 1'b1, 8'h00);
    xfer();
    while (rx_q.size() > 0) begin
      rx = rx_q.pop_front(); e = miso_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin errors++; $display("FAIL midrst_readback: got %h required %h", rx, e[7:0]); end
      end
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL midrst_write_missing: got %0d pending required 0", wr_q.size()); end
    $display("test_reset_mid_burst done");
  endtask

  // --------------------------------------------------------------------------
  // Sequence
  // --------------------------------------------------------------------------
  initial begin
    SCLK        = 1'b0;
    spi_if.CS_n = 1'b1;
    spi_if.MOSI = 1'b0;
    rstn        = 1'b0;
    chip_rdyn   = 1'b0;
    chip_state  = 3'b001;
    #5 rstn = 1'b1;
    test_reset();
    test_read_after_reset();
    test_single_write_read();
    test_burst_wrap();
    test_back_to_back();
    test_reserved();
    test_strobes();
    test_abort();
    test_reset_mid_burst();
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
